// File: rtl/booth_mult_pkg.sv
// Shared types and helpers for the Booth multiplier scheduler.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // Serial frame: start bit, 2*OP_W product bits, stop bit.
    function automatic int frame_len(input int op_w);
        return 2 * op_w + 2;
    endfunction

    function automatic booth_op_e booth_decode(input logic q0, input logic q_minus);
        booth_op_e op;
        case ({q0, q_minus})
            2'b10:   op = OP_SUB;
            2'b01:   op = OP_ADD;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add/sub, then arithmetic shift of {acc,Q,q_minus}.
module booth_step
    import booth_mult_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W:0]   acc,
    input  logic [OP_W-1:0] q,
    input  logic            q_minus,
    input  logic [OP_W:0]   m,
    output logic [OP_W:0]   acc_next,
    output logic [OP_W-1:0] q_next,
    output logic            q_minus_next
);

    logic [OP_W:0] sum_s;

    // Booth add/subtract selected by the low multiplier bit pair.
    always_comb begin
        sum_s = acc;
        case (booth_decode(q[0], q_minus))
            OP_ADD:  sum_s = acc + m;
            OP_SUB:  sum_s = acc - m;
            default: sum_s = acc;
        endcase
    end

    assign acc_next     = {sum_s[OP_W], sum_s[OP_W:1]};
    assign q_next       = {sum_s[0], q[OP_W-1:1]};
    assign q_minus_next = q[0];

endmodule

// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler for a shared radix-2 Booth multiplier with valid/ready response.
// Optional serial product framing on tx is enabled by defining BOOTH_SERIAL_TX_EN.
module booth_mult_scheduler
    import booth_mult_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int OP_W  = 4,
    parameter int ID_W  = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*OP_W-1:0]  req_multiplier,
    input  logic [N_REQ*OP_W-1:0]  req_multiplicand,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*OP_W-1:0]      rsp_product,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   tx
);

    localparam int CNT_W = $clog2(OP_W + 1);

    state_e              state_r, state_nx_s;
    logic [ID_W-1:0]     last_grant_r;
    logic [ID_W-1:0]     grant_idx_s;
    logic                grant_found_s;
    logic [N_REQ-1:0]    req_ready_s;
    logic [OP_W:0]       acc_r, m_r, acc_nx_s;
    logic [OP_W-1:0]     q_r, q_nx_s, mcand_s;
    logic                qm_r, qm_nx_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                last_iter_s;
    logic                exit_s;
    logic [2*OP_W-1:0]   product_r;
    logic [ID_W-1:0]     rsp_id_r;
    logic                rsp_valid_r;

    // Round-robin search starting just after the previous grant, only while idle.
    always_comb begin
        req_ready_s   = '0;
        grant_idx_s   = last_grant_r;
        grant_found_s = 1'b0;
        if (state_r == IDLE) begin
            for (int k = 1; k <= N_REQ; k++) begin
                if (!grant_found_s && req_valid[(int'(last_grant_r) + k) % N_REQ]) begin
                    grant_found_s = 1'b1;
                    grant_idx_s   = ID_W'((int'(last_grant_r) + k) % N_REQ);
                end else begin
                    grant_found_s = grant_found_s;
                end
            end
            if (grant_found_s) begin
                req_ready_s[grant_idx_s] = 1'b1;
            end else begin
                req_ready_s = '0;
            end
        end else begin
            grant_found_s = 1'b0;
        end
    end

    assign mcand_s     = req_multiplicand[int'(grant_idx_s)*OP_W +: OP_W];
    assign last_iter_s = (cnt_r == CNT_W'(OP_W - 1));

    booth_step #(.OP_W(OP_W)) u_step (
        .acc          (acc_r),
        .q            (q_r),
        .q_minus      (qm_r),
        .m            (m_r),
        .acc_next     (acc_nx_s),
        .q_next       (q_nx_s),
        .q_minus_next (qm_nx_s)
    );

`ifdef BOOTH_SERIAL_TX_EN
    localparam int FRAME_LEN = frame_len(OP_W);
    localparam int FRC_W     = $clog2(FRAME_LEN);

    logic [FRC_W-1:0]     frame_cnt_r;
    logic                 tx_r;
    logic [FRAME_LEN-1:0] frame_vec_s;

    assign frame_vec_s = {1'b1, product_r, 1'b0};
    // Exit waits for both the response handshake (now or earlier) and the stop bit.
    assign exit_s = (!rsp_valid_r || rsp_ready) && (frame_cnt_r == FRC_W'(FRAME_LEN - 1));

    // Frame shifter: start bit on DONE entry, then one frame bit per cycle.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            tx_r        <= 1'b1;
            frame_cnt_r <= '0;
        end else if (state_r == STEP && last_iter_s) begin
            tx_r        <= 1'b0;
            frame_cnt_r <= '0;
        end else if (state_r == DONE && frame_cnt_r != FRC_W'(FRAME_LEN - 1)) begin
            tx_r        <= frame_vec_s[frame_cnt_r + FRC_W'(1)];
            frame_cnt_r <= frame_cnt_r + FRC_W'(1);
        end else if (state_r != DONE) begin
            tx_r <= 1'b1;
        end
    end

    assign tx = tx_r;
`else
    assign exit_s = rsp_valid_r && rsp_ready;
    assign tx     = 1'b1;
`endif

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: if (grant_found_s) state_nx_s = STEP; else state_nx_s = IDLE;
            STEP: if (last_iter_s)   state_nx_s = DONE; else state_nx_s = STEP;
            DONE: if (exit_s)        state_nx_s = IDLE; else state_nx_s = DONE;
            default:                 state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture, Booth iterations and response registers.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            acc_r        <= '0;
            q_r          <= '0;
            qm_r         <= 1'b0;
            m_r          <= '0;
            cnt_r        <= '0;
            product_r    <= '0;
            rsp_id_r     <= '0;
            rsp_valid_r  <= 1'b0;
            last_grant_r <= ID_W'(N_REQ - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        acc_r        <= '0;
                        q_r          <= req_multiplier[int'(grant_idx_s)*OP_W +: OP_W];
                        qm_r         <= 1'b0;
                        m_r          <= {mcand_s[OP_W-1], mcand_s};
                        cnt_r        <= '0;
                        rsp_id_r     <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                    end
                end
                STEP: begin
                    acc_r <= acc_nx_s;
                    q_r   <= q_nx_s;
                    qm_r  <= qm_nx_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_iter_s) begin
                        product_r   <= {acc_nx_s[OP_W-1:0], q_nx_s};
                        rsp_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_valid_r && rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_s;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_product = product_r;
    assign rsp_id      = rsp_id_r;

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Directed self-checking bench for booth_mult_scheduler (N_REQ=2, OP_W=4).
module tb_booth_mult_scheduler;

    logic        CLK = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_multiplier;
    logic [7:0]  req_multiplicand;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_product;
    logic [0:0]  rsp_id;
    logic        tx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[10];

    booth_mult_scheduler #(.N_REQ(2), .OP_W(4)) dut (
        .CLK              (CLK),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_multiplier   (req_multiplier),
        .req_multiplicand (req_multiplicand),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_product      (rsp_product),
        .rsp_id           (rsp_id),
        .tx               (tx)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int r, output bit ok);
        int n = 0;
        while (!req_ready[r] && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        ok = req_ready[r];
    endtask

    task automatic wait_rsp(output int lat, output bit ok);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge CLK); #1;
            lat++;
        end
        ok = rsp_valid;
    endtask

    // Single request from requester r; returns product, id and accept-to-valid latency.
    task automatic mult_once(input int r, input logic [3:0] a, input logic [3:0] b,
                             output logic [7:0] prod, output logic [0:0] id,
                             output int lat, output bit ok);
        bit ok1, ok2;
        req_multiplier[r*4 +: 4]   = a;
        req_multiplicand[r*4 +: 4] = b;
        req_valid[r]               = 1'b1;
        #1;
        wait_ready(r, ok1);
        @(posedge CLK); #1;
        req_valid[r] = 1'b0;
        wait_rsp(lat, ok2);
        prod = rsp_product;
        id   = rsp_id;
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        ok = ok1 && ok2;
    endtask

    initial begin
        logic [7:0] prod;
        logic [0:0] id;
        logic [7:0] held_p;
        int lat, sa, sb, n;
        bit ok;
`ifdef BOOTH_SERIAL_TX_EN
        logic [9:0] exp_tx;
        exp_tx = 10'b1111110100;
`endif

        vecs[0] = '{4'd3,  4'hE, 8'hFA};
        vecs[1] = '{4'h8,  4'h8, 8'h40};
        vecs[2] = '{4'd7,  4'h8, 8'hC8};
        vecs[3] = '{4'h8,  4'd7, 8'hC8};
        vecs[4] = '{4'd0,  4'd5, 8'h00};
        vecs[5] = '{4'hF,  4'hF, 8'h01};
        vecs[6] = '{4'd5,  4'd3, 8'h0F};
        vecs[7] = '{4'hD,  4'd6, 8'hEE};
        vecs[8] = '{4'd7,  4'd7, 8'h31};
        vecs[9] = '{4'h8,  4'd1, 8'hF8};

        rst = 1'b0;
        req_valid = 2'b00;
        req_multiplier = 8'h00;
        req_multiplicand = 8'h00;
        rsp_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_product", {24'd0, rsp_product}, 32'd0);
        check("reset_id", {31'd0, rsp_id}, 32'd0);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_req_ready", {30'd0, req_ready}, 32'd0);
        rst = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 10; i++) begin
            mult_once(0, vecs[i].a, vecs[i].b, prod, id, lat, ok);
            check("vec_timeout", {31'd0, ok}, 32'd1);
            check("vec_product", {24'd0, prod}, {24'd0, vecs[i].p});
            check("vec_id", {31'd0, id}, 32'd0);
            check("vec_latency", lat, 32'd4);
        end

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                sa = (i > 7) ? i - 16 : i;
                sb = (j > 7) ? j - 16 : j;
                mult_once(0, 4'(i), 4'(j), prod, id, lat, ok);
                check("sweep_product", {24'd0, prod}, {24'd0, 8'(sa * sb)});
            end
        end

        // Reset while iterating on requester 1's operation.
        req_multiplier[7:4] = 4'd5;
        req_multiplicand[7:4] = 4'd5;
        req_valid = 2'b10;
        #1;
        wait_ready(1, ok);
        check("rst_mid_grant", {31'd0, ok}, 32'd1);
        @(posedge CLK); #1;
        req_valid = 2'b00;
        @(posedge CLK); #1;
        rst = 1'b0;
        @(posedge CLK); #1;
        check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_tx", {31'd0, tx}, 32'd1);
        check("rst_mid_id", {31'd0, rsp_id}, 32'd0);
        check("rst_mid_product", {24'd0, rsp_product}, 32'd0);
        check("rst_mid_idle", {30'd0, req_ready}, 32'd0);
        rst = 1'b1;

        // Both requesters held valid: grants alternate starting at 0.
        req_multiplier = {4'hF, 4'd2};
        req_multiplicand = {4'd5, 4'd3};
        req_valid = 2'b11;
        #1;
        check("rr_first_grant", {30'd0, req_ready}, 32'd1);
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 50) begin
                @(posedge CLK); #1;
                n++;
            end
            check("rr_grant", {30'd0, req_ready}, (g % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge CLK); #1;
            wait_rsp(lat, ok);
            check("rr_rsp_timeout", {31'd0, ok}, 32'd1);
            check("rr_id", {31'd0, rsp_id}, g % 2);
            check("rr_product", {24'd0, rsp_product}, (g % 2 == 0) ? 32'h06 : 32'hFB);
            rsp_ready = 1'b1;
            @(posedge CLK); #1;
            rsp_ready = 1'b0;
        end
        req_valid = 2'b00;

        // Backpressure on requester 1 while requester 0 waits.
        req_multiplier[7:4] = 4'h9;
        req_multiplicand[7:4] = 4'd3;
        req_valid = 2'b10;
        #1;
        wait_ready(1, ok);
        check("bp_grant", {31'd0, ok}, 32'd1);
        @(posedge CLK); #1;
        req_valid = 2'b01;
        wait_rsp(lat, ok);
        check("bp_rsp_timeout", {31'd0, ok}, 32'd1);
        held_p = 8'hEB;
        for (int c = 0; c < 6; c++) begin
            check("bp_product", {24'd0, rsp_product}, {24'd0, held_p});
            check("bp_id", {31'd0, rsp_id}, 32'd1);
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_no_grant", {30'd0, req_ready}, 32'd0);
`ifndef BOOTH_SERIAL_TX_EN
            check("bp_tx_idle", {31'd0, tx}, 32'd1);
`endif
            @(posedge CLK); #1;
        end
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
`ifndef BOOTH_SERIAL_TX_EN
        check("bp_grant_after", {30'd0, req_ready}, 32'd1);
`endif
        wait_ready(0, ok);
        @(posedge CLK); #1;
        req_valid = 2'b00;
        wait_rsp(lat, ok);
        check("bp_next_product", {24'd0, rsp_product}, 32'h06);
        check("bp_next_id", {31'd0, rsp_id}, 32'd0);
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;

`ifdef BOOTH_SERIAL_TX_EN
        // Frame of 8'hFA with rsp_ready already high at DONE entry.
        req_multiplier[3:0] = 4'd3;
        req_multiplicand[3:0] = 4'hE;
        req_valid = 2'b01;
        #1;
        wait_ready(0, ok);
        @(posedge CLK); #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        wait_rsp(lat, ok);
        check("tx_rsp_timeout", {31'd0, ok}, 32'd1);
        req_valid = 2'b01;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("tx_bit", {31'd0, tx}, {31'd0, exp_tx[k]});
            check("tx_done_hold", {30'd0, req_ready}, 32'd0);
            @(posedge CLK); #1;
        end
        check("tx_idle_high", {31'd0, tx}, 32'd1);
        check("tx_exit_grant", {30'd0, req_ready}, 32'd1);
        rsp_ready = 1'b0;
        req_valid = 2'b00;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
